// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner.
// Drives the keypad rows low one at a time and samples the column lines for
// each row. A key must give the same result for several complete scans before
// a press or a release is accepted. Each accepted press produces one key code,
// which is offered to the CPU-side logic over a valid/ready handshake.
module keypad_matrix_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  localparam int CW             = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic            key_down,
  output logic            overrun,
  input  logic            clr_overrun
);

  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int NW  = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  logic [COLS-1:0] colMeta_q;
  logic [COLS-1:0] colSync_q;
  logic [DW-1:0]   div_q;
  logic [RW-1:0]   rowIdx_q;
  logic [RW-1:0]   rowIdx_d;
  logic [ROWS-1:0] rowN_q;
  logic [1:0]      pressCnt_q;
  logic [1:0]      pressCnt_d;
  logic [CW-1:0]   firstCode_q;
  logic [CW-1:0]   firstCode_d;
  logic [CLW-1:0]  lowCol;
  logic [CW-1:0]   rowCode;

  state_t          state_q;
  logic [CW-1:0]   cand_q;
  logic [NW-1:0]   cnt_q;
  logic [NW-1:0]   cntInc;
  logic            keyDown_q;
  logic            keyValid_q;
  logic [CW-1:0]   keyCode_q;
  logic            overrun_q;

  logic            slotEnd;
  logic            lastRow;
  logic            frameEnd;
  logic            frameNone;
  logic            frameSingle;
  logic            sameCand;
  logic            debounceDone;
  logic            evtFire;
  logic            dropEvent;

  assign slotEnd  = (div_q == DW'(SCAN_DIV - 1));
  assign lastRow  = (rowIdx_q == RW'(ROWS - 1));
  assign frameEnd = slotEnd && lastRow;
  assign rowIdx_d = lastRow ? '0 : rowIdx_q + RW'(1);

  // Fold the current row's pressed columns into this frame's running totals:
  // a pressed-key count that saturates at two, and the lowest pressed code.
  always_comb begin
    pressCnt_d = pressCnt_q;
    lowCol     = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!colSync_q[c]) begin
        lowCol = CLW'(c);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (!colSync_q[c] && (pressCnt_d != 2'd2)) begin
        pressCnt_d = pressCnt_d + 2'd1;
      end
    end
    rowCode     = CW'(rowIdx_q) * CW'(COLS) + CW'(lowCol);
    firstCode_d = (pressCnt_q == 2'd0) ? rowCode : firstCode_q;
  end

  // Result of the frame that completes on this cycle; only looked at on frameEnd.
  assign frameNone    = (pressCnt_d == 2'd0);
  assign frameSingle  = (pressCnt_d == 2'd1);
  assign sameCand     = frameSingle && (firstCode_d == cand_q);
  assign cntInc       = cnt_q + NW'(1);
  assign debounceDone = (cntInc == NW'(DEBOUNCE_FRAMES));
  assign evtFire      = frameEnd && (state_q == DEBOUNCE) && sameCand && debounceDone;
  assign dropEvent    = evtFire && keyValid_q && !key_ready;

  // Column synchronizer, slot divider, row rotation and frame accumulation.
  // The row drive is registered together with the row index, so the new row
  // appears on the cycle after the slot's terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      colMeta_q   <= '1;
      colSync_q   <= '1;
      div_q       <= '0;
      rowIdx_q    <= '0;
      rowN_q      <= ~ROWS'(1);
      pressCnt_q  <= 2'd0;
      firstCode_q <= '0;
    end else begin
      colMeta_q <= col_n;
      colSync_q <= colMeta_q;
      if (slotEnd) begin
        div_q    <= '0;
        rowIdx_q <= rowIdx_d;
        rowN_q   <= ~(ROWS'(1) << rowIdx_d);
        if (lastRow) begin
          pressCnt_q  <= 2'd0;
          firstCode_q <= '0;
        end else begin
          pressCnt_q  <= pressCnt_d;
          firstCode_q <= firstCode_d;
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  // Debounce FSM, advanced once per completed frame. key_down is registered
  // together with the state so that it is high in PRESSED and RELEASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      keyDown_q <= 1'b0;
    end else if (frameEnd) begin
      case (state_q)
        IDLE: begin
          if (frameSingle) begin
            cand_q  <= firstCode_d;
            cnt_q   <= NW'(1);
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sameCand) begin
            if (debounceDone) begin
              state_q   <= PRESSED;
              keyDown_q <= 1'b1;
            end else begin
              cnt_q <= cntInc;
            end
          end else if (frameSingle) begin
            cand_q <= firstCode_d;
            cnt_q  <= NW'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        PRESSED: begin
          if (frameNone) begin
            cnt_q   <= NW'(1);
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (frameNone) begin
            if (debounceDone) begin
              state_q   <= IDLE;
              keyDown_q <= 1'b0;
            end else begin
              cnt_q <= cntInc;
            end
          end else begin
            state_q <= PRESSED;
          end
        end
        default: begin
          state_q   <= IDLE;
          keyDown_q <= 1'b0;
        end
      endcase
    end
  end

  // One-deep output holding register. A new event is taken whenever the slot
  // is empty or being emptied on the same cycle; otherwise it is dropped and
  // flagged. A new drop outranks a simultaneous clear of the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyValid_q <= 1'b0;
      keyCode_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (evtFire && (!keyValid_q || key_ready)) begin
        keyValid_q <= 1'b1;
        keyCode_q  <= cand_q;
      end else if (keyValid_q && key_ready) begin
        keyValid_q <= 1'b0;
      end
      if (dropEvent) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign row_n     = rowN_q;
  assign key_valid = keyValid_q;
  assign key_code  = keyCode_q;
  assign key_down  = keyDown_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Testbench for keypad_matrix_scanner.
// A simulated key matrix answers the row drive. Stimulus is applied one whole
// frame at a time. A reference model works on complete frames and keeps a
// short history of frame results. Expected key codes are queued, and a
// separate monitor pops and compares them on each handshake transfer.
module tb_keypad_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DF       = 3;
  localparam int FRAME    = ROWS * SCAN_DIV;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_ready = 1'b0;
  logic            key_down;
  logic            overrun;
  logic            clr_overrun = 1'b0;

  logic [15:0]     pressed = '0;

  int              vectors = 0;
  int              miscompares = 0;

  logic [3:0]      expQ[$];
  int              hist[$];
  bit              held = 1'b0;
  bit              expOverrun = 1'b0;

  keypad_matrix_scanner #(
    .ROWS(ROWS),
    .COLS(COLS),
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .key_down(key_down),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Ideal key matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!row_n[r] && pressed[r*COLS + c]) begin
          col_n[c] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed transfer must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_transfer: actual code=%0h required=no transfer at %0t", key_code, $time);
      end else begin
        checkOutput("xfer_code", 32'(key_code), 32'(expQ.pop_front()));
      end
    end
  end

  // Frame result: -1 none, -2 several keys, otherwise the single key's code.
  function automatic int classify(input logic [15:0] ks);
    int n;
    n = $countones(ks);
    if (n == 0) return -1;
    if (n > 1) return -2;
    for (int k = 0; k < 16; k++) begin
      if (ks[k]) return k;
    end
    return -1;
  endfunction

  // Press: DF identical single-key frames in a row while not held.
  // Release: DF empty frames in a row while held.
  task automatic modelFrame(input int r, output bit evt, output int code);
    bit same;
    evt  = 1'b0;
    code = 0;
    if (!held) begin
      hist.push_back(r);
      if (hist.size() > DF) void'(hist.pop_front());
      if (hist.size() == DF && r >= 0) begin
        same = 1'b1;
        foreach (hist[k]) if (hist[k] != r) same = 1'b0;
        if (same) begin
          evt  = 1'b1;
          code = r;
          held = 1'b1;
          hist.delete();
        end
      end
    end else if (r == -1) begin
      hist.push_back(r);
      if (hist.size() >= DF) begin
        held = 1'b0;
        hist.delete();
      end
    end else begin
      hist.delete();
    end
  endtask

  function automatic logic [15:0] kb(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  // Hold a key set for one whole frame. readyMode: 0 low, 1 high,
  // 2 random then high for the second half, 3 high on the frame's last cycle.
  task automatic applyStimulus(input logic [15:0] ks, input int readyMode, input int clrCycle);
    logic [3:0] expRow;
    bit         prevReady;
    bit         evt;
    int         code;
    pressed   = ks;
    prevReady = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      case (readyMode)
        0: key_ready = 1'b0;
        1: key_ready = 1'b1;
        2: key_ready = (i >= FRAME/2) ? 1'b1 : 1'($urandom_range(0, 1));
        default: key_ready = (i == FRAME - 1);
      endcase
      clr_overrun = (i == clrCycle);
      expRow = ~(4'b0001 << (i / SCAN_DIV));
      checkOutput("row_n", 32'(row_n), 32'(expRow));
      if (i != 0 && prevReady) checkOutput("valid_after_accept", 32'(key_valid), 32'd0);
      prevReady = key_ready;
      @(posedge clk);
      #1;
    end
    clr_overrun = 1'b0;
    if (clrCycle >= 0) expOverrun = 1'b0;
    modelFrame(classify(ks), evt, code);
    if (evt) begin
      if (expQ.size() == 0) expQ.push_back(4'(code));
      else expOverrun = 1'b1;
    end
    checkOutput("key_down", 32'(key_down), 32'(held));
    checkOutput("overrun", 32'(overrun), 32'(expOverrun));
    if (expQ.size() != 0) begin
      checkOutput("pending_valid", 32'(key_valid), 32'd1);
      checkOutput("pending_code", 32'(key_code), 32'(expQ[0]));
    end else begin
      checkOutput("idle_valid", 32'(key_valid), 32'd0);
    end
    if ((readyMode == 1 || readyMode == 2) && !evt) checkOutput("drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput("rst_row_n", 32'(row_n), 32'hE);
    checkOutput("rst_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_code", 32'(key_code), 32'd0);
    checkOutput("rst_down", 32'(key_down), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    hist.delete();
    expQ.delete();
    held       = 1'b0;
    expOverrun = 1'b0;
  endtask

  // Bound on total simulated time.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized key patterns.
  initial begin
    int sel;
    int a;
    int b;
    int holdFrames;
    logic [15:0] pat;

    applyReset(3);
    repeat (2) applyStimulus('0, 1, -1);

    repeat (3) applyStimulus(kb(9), 0, -1);
    applyStimulus(kb(9), 1, -1);
    repeat (3) applyStimulus('0, 1, -1);

    applyStimulus(kb(10), 1, -1);
    applyStimulus('0, 1, -1);
    applyStimulus(kb(10), 1, -1);
    applyStimulus(kb(10), 1, -1);
    applyStimulus('0, 1, -1);
    repeat (3) applyStimulus(kb(10), 1, -1);
    repeat (3) applyStimulus('0, 1, -1);

    repeat (5) applyStimulus(kb(0) | kb(5), 1, -1);
    applyStimulus('0, 1, -1);

    repeat (3) applyStimulus(kb(3), 0, -1);
    repeat (3) applyStimulus('0, 0, -1);
    repeat (2) applyStimulus(kb(7), 0, -1);
    applyStimulus(kb(7), 0, FRAME - 1);
    applyStimulus('0, 0, 5);
    repeat (2) applyStimulus('0, 0, -1);
    repeat (2) applyStimulus(kb(12), 0, -1);
    applyStimulus(kb(12), 3, -1);
    repeat (3) applyStimulus('0, 1, -1);

    repeat (2) applyStimulus(kb(6), 1, -1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    applyReset(1);
    repeat (3) applyStimulus(kb(6), 1, -1);
    repeat (3) applyStimulus('0, 1, -1);

    for (int burst = 0; burst < 30; burst++) begin
      sel = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 15));
      b   = (a + int'($urandom_range(1, 15))) % 16;
      if (sel < 3) pat = '0;
      else if (sel < 8) pat = kb(a);
      else pat = kb(a) | kb(b);
      holdFrames = int'($urandom_range(1, 5));
      repeat (holdFrames) applyStimulus(pat, 2, -1);
    end
    repeat (4) applyStimulus('0, 1, -1);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
